mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 153 +++++++++++++++
 tb/tb_mem_access.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: decodes load/store/LL/SC ops, runs a req/ack data-bus
// handshake through a three-state FSM, and formats load results big-endian.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        LLbit_i,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        stallreq,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        LLbit_we_o,
  output logic        LLbit_value_o,
  output logic        misalign_o
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8,
                         OP_LL = 4'd9, OP_SC  = 4'd10;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_mem, is_load, is_store, sext;
  logic [1:0]  sz;
  logic        is_ll, is_sc, misal, sc_fail, bus_op;
  logic [3:0]  sel_raw;
  logic [31:0] st_data, ld_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Op decode: class, access size and sign handling.
  always_comb begin
    is_mem = 1'b0; is_load = 1'b0; is_store = 1'b0; sz = SZ_W; sext = 1'b0;
    case (mem_op)
      OP_LB:  begin is_mem = 1'b1; is_load  = 1'b1; sz = SZ_B; sext = 1'b1; end
      OP_LBU: begin is_mem = 1'b1; is_load  = 1'b1; sz = SZ_B; end
      OP_LH:  begin is_mem = 1'b1; is_load  = 1'b1; sz = SZ_H; sext = 1'b1; end
      OP_LHU: begin is_mem = 1'b1; is_load  = 1'b1; sz = SZ_H; end
      OP_LW:  begin is_mem = 1'b1; is_load  = 1'b1; end
      OP_LL:  begin is_mem = 1'b1; is_load  = 1'b1; end
      OP_SB:  begin is_mem = 1'b1; is_store = 1'b1; sz = SZ_B; end
      OP_SH:  begin is_mem = 1'b1; is_store = 1'b1; sz = SZ_H; end
      OP_SW:  begin is_mem = 1'b1; is_store = 1'b1; end
      OP_SC:  begin is_mem = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
  end

  assign is_ll   = (mem_op == OP_LL);
  assign is_sc   = (mem_op == OP_SC);
  assign misal   = is_mem && ((sz == SZ_H && mem_addr[0]) ||
                              (sz == SZ_W && mem_addr[1:0] != 2'b00));
  // A failed SC never touches the bus; misalignment takes priority over it.
  assign sc_fail = is_sc && !LLbit_i;
  assign bus_op  = is_mem && !misal && !sc_fail;

  // Big-endian lane select, store replication and load extraction.
  always_comb begin
    sel_raw = 4'b1111;
    st_data = mem_reg2;
    case (sz)
      SZ_B: begin
        sel_raw = 4'b1000 >> mem_addr[1:0];
        st_data = {4{mem_reg2[7:0]}};
      end
      SZ_H: begin
        sel_raw = mem_addr[1] ? 4'b0011 : 4'b1100;
        st_data = {2{mem_reg2[15:0]}};
      end
      default: ;
    endcase
    case (mem_addr[1:0])
      2'd0:    ld_b = rdata_q[31:24];
      2'd1:    ld_b = rdata_q[23:16];
      2'd2:    ld_b = rdata_q[15:8];
      default: ld_b = rdata_q[7:0];
    endcase
    ld_h = mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (sz)
      SZ_B:    ld_data = {{24{sext & ld_b[7]}}, ld_b};
      SZ_H:    ld_data = {{16{sext & ld_h[15]}}, ld_h};
      default: ld_data = rdata_q;
    endcase
  end

  // Next state: wait for ack, then a single DONE cycle to present the result.
  always_comb begin
    state_d = S_IDLE;
    rdata_d = rdata_q;
    if (state_q != S_DONE && bus_op) begin
      if (bus_ack) begin
        state_d = S_DONE;
        rdata_d = bus_rdata;
      end else begin
        state_d = S_WAIT;
      end
    end
  end

  // State and captured read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus drive and write-back outputs.
  always_comb begin
    bus_req = 1'b0; bus_we = 1'b0; bus_sel = 4'b0000;
    bus_addr = {mem_addr[31:2], 2'b00};
    bus_wdata = st_data;
    stallreq = 1'b0;
    wd_o = mem_wd; wreg_o = 1'b0; wdata_o = 32'd0;
    LLbit_we_o = 1'b0; LLbit_value_o = 1'b0; misalign_o = 1'b0;
    if (rst) begin
      wd_o = 5'd0; bus_addr = 32'd0; bus_wdata = 32'd0;
    end else if (!is_mem) begin
      wreg_o = mem_wreg; wdata_o = mem_wdata;
    end else if (misal) begin
      misalign_o = 1'b1;
    end else if (sc_fail) begin
      wreg_o = 1'b1;
    end else if (state_q != S_DONE) begin
      bus_req = 1'b1; bus_we = is_store; bus_sel = sel_raw; stallreq = 1'b1;
    end else if (is_sc) begin
      wreg_o = 1'b1; wdata_o = 32'd1; LLbit_we_o = 1'b1;
    end else if (is_load) begin
      wreg_o = 1'b1; wdata_o = ld_data;
      LLbit_we_o = is_ll; LLbit_value_o = is_ll;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a scoreboard of expected write-back results.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_reg2, mem_wdata, bus_rdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, LLbit_i, bus_ack;
  logic        bus_req, bus_we, stallreq, wreg_o, LLbit_we_o, LLbit_value_o, misalign_o;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, wdata_o;
  logic [4:0]  wd_o;

  typedef struct packed {
    logic [31:0] wdata;
    logic        wreg;
    logic        llwe;
    logic        llval;
  } exp_t;
  exp_t sb[$];

  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .mem_op(mem_op), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .LLbit_i(LLbit_i),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we),
    .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .stallreq(stallreq),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .LLbit_we_o(LLbit_we_o),
    .LLbit_value_o(LLbit_value_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Run one bus op: ack arrives in cycle ack_cyc (1-based), then check the DONE cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input int ack_cyc, input logic [31:0] rdata,
                        input logic [3:0] e_sel, input logic e_we, input logic [31:0] e_bwd,
                        input logic [31:0] e_wdata, input logic e_wreg,
                        input logic e_llwe, input logic e_llval);
    exp_t e;
    sb.push_back('{e_wdata, e_wreg, e_llwe, e_llval});
    mem_op = op; mem_addr = addr; mem_reg2 = reg2; mem_wd = 5'd7;
    for (int c = 1; c <= ack_cyc; c++) begin
      bus_ack = (c == ack_cyc);
      bus_rdata = bus_ack ? rdata : 32'hDEAD_BEEF;
      #1;
      chk({tag, ".stall"}, {31'd0, stallreq}, 32'd1);
      chk({tag, ".req"}, {31'd0, bus_req}, 32'd1);
      if (c == 1) begin
        chk({tag, ".sel"}, {28'd0, bus_sel}, {28'd0, e_sel});
        chk({tag, ".we"}, {31'd0, bus_we}, {31'd0, e_we});
        chk({tag, ".addr"}, bus_addr, {addr[31:2], 2'b00});
        if (e_we) chk({tag, ".bwdata"}, bus_wdata, e_bwd);
        chk({tag, ".wreg_pre"}, {31'd0, wreg_o}, 32'd0);
      end
      @(negedge clk);
    end
    bus_ack = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk({tag, ".done_stall"}, {31'd0, stallreq}, 32'd0);
    chk({tag, ".done_req"}, {31'd0, bus_req}, 32'd0);
    e = sb.pop_front();
    chk({tag, ".wdata"}, wdata_o, e.wdata);
    chk({tag, ".wreg"}, {31'd0, wreg_o}, {31'd0, e.wreg});
    chk({tag, ".llwe"}, {31'd0, LLbit_we_o}, {31'd0, e.llwe});
    chk({tag, ".llval"}, {31'd0, LLbit_value_o}, {31'd0, e.llval});
    chk({tag, ".wd"}, {27'd0, wd_o}, 32'd7);
    @(negedge clk);
    mem_op = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_op = 4'd5; mem_addr = 32'h100; mem_reg2 = 32'h0; mem_wd = 5'h1F;
    mem_wreg = 1'b1; mem_wdata = 32'hFFFF_FFFF; LLbit_i = 1'b0; bus_ack = 1'b0;
    bus_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst.out", {bus_req, bus_we, bus_sel, stallreq, wreg_o, LLbit_we_o, LLbit_value_o, misalign_o},
        32'd0);
    chk("rst.wd", {27'd0, wd_o}, 32'd0);
    chk("rst.wdata", wdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_op = 4'd0; mem_wd = 5'h1A; mem_wreg = 1'b1; mem_wdata = 32'h1234_5678;
    #1;
    chk("pass.wd", {27'd0, wd_o}, 32'h1A);
    chk("pass.wreg", {31'd0, wreg_o}, 32'd1);
    chk("pass.wdata", wdata_o, 32'h1234_5678);
    chk("pass.busy", {30'd0, stallreq, bus_req}, 32'd0);
    @(negedge clk);

    run_op("lw",  4'd5, 32'h100, 32'h0, 3, 32'h1122_3344, 4'b1111, 1'b0, 32'h0, 32'h1122_3344, 1'b1, 1'b0, 1'b0);
    run_op("lb",  4'd1, 32'h103, 32'h0, 1, 32'h0000_00F0, 4'b0001, 1'b0, 32'h0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
    run_op("lbu", 4'd2, 32'h103, 32'h0, 2, 32'h0000_00F0, 4'b0001, 1'b0, 32'h0, 32'h0000_00F0, 1'b1, 1'b0, 1'b0);
    run_op("lb1", 4'd1, 32'h101, 32'h0, 1, 32'h00A5_0000, 4'b0100, 1'b0, 32'h0, 32'hFFFF_FFA5, 1'b1, 1'b0, 1'b0);
    run_op("lh",  4'd3, 32'h102, 32'h0, 1, 32'h1234_ABCD, 4'b0011, 1'b0, 32'h0, 32'hFFFF_ABCD, 1'b1, 1'b0, 1'b0);
    run_op("lhu", 4'd4, 32'h100, 32'h0, 1, 32'hABCD_1234, 4'b1100, 1'b0, 32'h0, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0);
    run_op("sh",  4'd7, 32'h202, 32'hAAAA_BEEF, 2, 32'h0, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("sb",  4'd6, 32'h201, 32'h1234_56C3, 1, 32'h0, 4'b0100, 1'b1, 32'hC3C3_C3C3, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("ll",  4'd9, 32'h400, 32'h0, 2, 32'h5566_7788, 4'b1111, 1'b0, 32'h0, 32'h5566_7788, 1'b1, 1'b1, 1'b1);

    // Misaligned word and half accesses
    mem_op = 4'd5; mem_addr = 32'h101; #1;
    chk("mis_lw.flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_lw.quiet", {29'd0, bus_req, stallreq, wreg_o}, 32'd0);
    @(negedge clk);
    mem_op = 4'd7; mem_addr = 32'h201; #1;
    chk("mis_sh.flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_sh.quiet", {29'd0, bus_req, stallreq, LLbit_we_o}, 32'd0);
    @(negedge clk);

    // SC with LLbit clear: resolves in the same cycle without bus traffic
    mem_op = 4'd10; mem_addr = 32'h300; mem_reg2 = 32'hCAFE_F00D; LLbit_i = 1'b0; #1;
    chk("scf.quiet", {30'd0, bus_req, stallreq}, 32'd0);
    chk("scf.wreg", {31'd0, wreg_o}, 32'd1);
    chk("scf.wdata", wdata_o, 32'd0);
    chk("scf.llwe", {31'd0, LLbit_we_o}, 32'd0);
    @(negedge clk);
    mem_op = 4'd0; @(negedge clk);
    LLbit_i = 1'b1;
    run_op("sc", 4'd10, 32'h300, 32'hCAFE_F00D, 1, 32'h0, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'd1, 1'b1, 1'b1, 1'b0);
    LLbit_i = 1'b0;

    // Reset in the middle of a waiting load
    mem_op = 4'd5; mem_addr = 32'h500; bus_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("mid.waiting", {31'd0, stallreq}, 32'd1);
    rst = 1'b1; #1;
    chk("mid.rst_out", {30'd0, bus_req, stallreq}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_op = 4'd0; #1;
    chk("mid.idle", {30'd0, bus_req, stallreq}, 32'd0);
    @(negedge clk);
    run_op("post", 4'd5, 32'h504, 32'h0, 2, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0);

    chk("sb.empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
